// File: rtl/set_assoc_cache_memory_pkg.sv
// Shared geometry defaults, sizing helper and per-way metadata type for the
// set-associative cache storage.
package cache_pkg;

    localparam int DEF_WORD_WIDTH     = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_SETS           = 32;
    localparam int DEF_WAYS           = 2;
    localparam int DEF_TAG_WIDTH      = 3;

    // Metadata carries tags at a fixed width so one struct type serves any TAG_WIDTH up to this.
    localparam int MAX_TAG_WIDTH = 16;

    typedef logic [MAX_TAG_WIDTH-1:0] line_tag_t;

    typedef struct packed {
        logic      valid;
        logic      dirty;
        line_tag_t tag;
    } line_meta_t;

    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/set_assoc_cache_memory_way.sv
// One way of the cache: data, tag, valid and dirty per set, read combinationally
// at the presented index and written on the rising edge.
module cache_way
    import cache_pkg::*;
#(
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int SETS           = DEF_SETS,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
    localparam int OFF_W         = clog2_min1(WORDS_PER_LINE),
    localparam int IDX_W         = clog2_min1(SETS),
    localparam int LINE_W        = WORD_WIDTH * WORDS_PER_LINE,
    localparam int BYTES         = WORD_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     index,
    input  logic [OFF_W-1:0]     offset,
    input  logic [TAG_WIDTH-1:0] tag,
    input  logic                 refill_en,
    input  logic                 update_en,
    input  logic                 invalidate_en,
    input  logic [BYTES-1:0]     byte_en,
    input  logic [LINE_W-1:0]    line_data,
    input  logic [WORD_WIDTH-1:0] write_data,
    output line_meta_t           meta,
    output logic [LINE_W-1:0]    line
);

    logic [LINE_W-1:0]    data_mem [SETS];
    logic [TAG_WIDTH-1:0] tag_mem  [SETS];
    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;

    // Data and tags are never reset; a line only becomes observable once valid is set.
    always_ff @(posedge clk) begin
        if (!invalidate_en) begin
            if (refill_en) begin
                data_mem[index] <= line_data;
                tag_mem[index]  <= tag;
            end else if (update_en) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byte_en[b]) begin
                        data_mem[index][int'(offset)*WORD_WIDTH + b*8 +: 8] <= write_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (invalidate_en) begin
            valid_q[index] <= 1'b0;
            dirty_q[index] <= 1'b0;
        end else if (refill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (update_en) begin
            dirty_q[index] <= 1'b1;
        end
    end

    assign meta.valid = valid_q[index];
    assign meta.dirty = dirty_q[index];
    assign meta.tag   = line_tag_t'(tag_mem[index]);
    assign line       = data_mem[index];

endmodule

// File: rtl/set_assoc_cache_memory.sv
// N-way set-associative cache storage: WAYS cache_way copies plus hit detection,
// victim selection and a per-set round-robin replacement pointer.
module set_assoc_cache_memory
    import cache_pkg::*;
#(
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int SETS           = DEF_SETS,
    parameter int WAYS           = DEF_WAYS,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
    localparam int OFF_W         = clog2_min1(WORDS_PER_LINE),
    localparam int IDX_W         = clog2_min1(SETS),
    localparam int WAY_W         = clog2_min1(WAYS),
    localparam int LINE_W        = WORD_WIDTH * WORDS_PER_LINE,
    localparam int BYTES         = WORD_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RE,
    input  logic                  refill,
    input  logic                  update,
    input  logic                  invalidate,
    input  logic [OFF_W-1:0]      offset,
    input  logic [IDX_W-1:0]      index,
    input  logic [TAG_WIDTH-1:0]  tag,
    input  logic [BYTES-1:0]      byte_en,
    input  logic [LINE_W-1:0]     line_data,
    input  logic [WORD_WIDTH-1:0] write_data,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic [WAY_W-1:0]      victim_way,
    output logic                  victim_dirty,
    output logic [TAG_WIDTH-1:0]  victim_tag,
    output logic [LINE_W-1:0]     victim_line
);

    line_meta_t        way_meta [WAYS];
    logic [LINE_W-1:0] way_line [WAYS];
    logic [WAY_W-1:0]  rr_ptr   [SETS];
    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   way_match;
    logic [WAYS-1:0]   refill_sel;
    logic [WAYS-1:0]   update_sel;
    logic [WAY_W-1:0]  target_way;
    logic              set_full;
    logic              do_refill;
    logic              do_update;
    line_tag_t         access_tag;

    assign access_tag = line_tag_t'(tag);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_valid[w] = way_meta[w].valid;
        assign way_match[w] = way_meta[w].valid && (way_meta[w].tag == access_tag);

        cache_way #(
            .WORD_WIDTH     (WORD_WIDTH),
            .WORDS_PER_LINE (WORDS_PER_LINE),
            .SETS           (SETS),
            .TAG_WIDTH      (TAG_WIDTH)
        ) u_way (
            .clk           (clk),
            .reset         (reset),
            .index         (index),
            .offset        (offset),
            .tag           (tag),
            .refill_en     (refill_sel[w]),
            .update_en     (update_sel[w]),
            .invalidate_en (invalidate),
            .byte_en       (byte_en),
            .line_data     (line_data),
            .write_data    (write_data),
            .meta          (way_meta[w]),
            .line          (way_line[w])
        );
    end

    // Scanning downwards lets the lowest-numbered matching / invalid way win.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_way = rr_ptr[index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_valid[w]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    assign set_full     = &way_valid;
    assign target_way   = hit ? hit_way : victim_way;
    assign do_refill    = refill && !invalidate;
    assign do_update    = update && !invalidate && !refill && hit;

    assign victim_dirty = way_meta[victim_way].valid && way_meta[victim_way].dirty;
    assign victim_tag   = way_meta[victim_way].tag[TAG_WIDTH-1:0];
    assign victim_line  = way_line[victim_way];

    always_comb begin
        refill_sel = '0;
        update_sel = '0;
        for (int w = 0; w < WAYS; w++) begin
            refill_sel[w] = do_refill && (target_way == WAY_W'(w));
            update_sel[w] = do_update && (hit_way == WAY_W'(w));
        end
    end

    always_comb begin
        read_data = '0;
        if (RE && hit) begin
            read_data = way_line[hit_way][int'(offset)*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    // The pointer only moves when a full set loses the line it was pointing at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else if (do_refill && set_full && (target_way == rr_ptr[index])) begin
            rr_ptr[index] <= (rr_ptr[index] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[index] + 1'b1;
        end
    end

endmodule
